// File: rtl/seq_decode_writeback_if.sv
// rtl/seq_decode_writeback_if.sv - decode/write-back stage bus between fetch/execute and the register file
interface seq_decode_writeback_if #(
  parameter int WIDTH = 64
) ();

  // Instruction fields from fetch
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [3:0]       rA;
  logic [3:0]       rB;

  // Results coming back for write-back
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic             cnd;
  logic             wb_en;

  // Operands and destinations produced by decode
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [3:0]       dstE;
  logic [3:0]       dstM;

  // Pipeline side: drives instruction fields and results, observes operands
  modport master (
    output icode, ifun, rA, rB, valE, valM, cnd, wb_en,
    input  valA, valB, dstE, dstM
  );

  // Decode/write-back stage side
  modport slave (
    input  icode, ifun, rA, rB, valE, valM, cnd, wb_en,
    output valA, valB, dstE, dstM
  );

endinterface

// File: rtl/seq_decode_writeback.sv
// rtl/seq_decode_writeback.sv - SEQ Y86-64 decode and write-back stage with 15-entry register file
module seq_decode_writeback #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = WIDTH'(64'h0000_0100)
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_decode_writeback_if.slave bus,
  input  logic [3:0]          dbg_sel,
  output logic [WIDTH-1:0]    dbg_val
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;

  // ifun only selects the ALU op / condition, which execute resolves into cnd
  logic unused_ifun;
  assign unused_ifun = ^bus.ifun;

  // Register file state; index 15 is "no register" and has no storage
  logic [WIDTH-1:0] regs_q [15];
  logic [WIDTH-1:0] regs_d [15];

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  // Operand source selection by instruction class
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    unique case (bus.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.rA;
      I_RET, I_POPQ:                      src_a = R_RSP;
      default:                            src_a = R_NONE;
    endcase
    unique case (bus.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = bus.rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = R_RSP;
      default:                            src_b = R_NONE;
    endcase
  end

  // Destination selection; a failed cmov turns into "no register"
  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    unique case (bus.icode)
      I_RRMOVQ:                           dst_e = bus.cnd ? bus.rB : R_NONE;
      I_IRMOVQ, I_OPQ:                    dst_e = bus.rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = R_RSP;
      default:                            dst_e = R_NONE;
    endcase
    unique case (bus.icode)
      I_MRMOVQ, I_POPQ:                   dst_m = bus.rA;
      default:                            dst_m = R_NONE;
    endcase
  end

  // Combinational reads of pre-edge contents; no bypass of the pending write
  always_comb begin
    bus.valA = (src_a == R_NONE) ? '0 : regs_q[src_a];
    bus.valB = (src_b == R_NONE) ? '0 : regs_q[src_b];
    bus.dstE = dst_e;
    bus.dstM = dst_m;
    dbg_val  = (dbg_sel == R_NONE) ? '0 : regs_q[dbg_sel];
  end

  // Next register-file contents; the M write is applied last so it wins on dstE == dstM
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) begin
      if (dst_e != R_NONE) regs_d[dst_e] = bus.valE;
      if (dst_m != R_NONE) regs_d[dst_m] = bus.valM;
    end
  end

  // Register file update; reset loads %rsp with its initial stack pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == int'(R_RSP)) ? RSP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
